// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I constants, instruction field positions and the fetch queue payload.
// Pure definitions: no latency and no backpressure of its own.
// Imported by fetch_unit and fetch_buf users with import rv32_pkg::*.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSN_BYTES       = 32'd4;
  localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 7;
  localparam int FUN3_LSB   = 12;
  localparam int FUN3_W     = 3;
  localparam int FUN7_BIT   = 30;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0f;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [XLEN-1:0] w);
    return w[OPCODE_LSB +: OPCODE_W];
  endfunction

  function automatic logic [FUN3_W-1:0] get_fun3(input logic [XLEN-1:0] w);
    return w[FUN3_LSB +: FUN3_W];
  endfunction

  function automatic logic get_fun7(input logic [XLEN-1:0] w);
    return w[FUN7_BIT];
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry synchronous FIFO with flush and occupancy count, generic payload width.
// Latency: a push is visible at head_dat/count the cycle after it is accepted; no bypass.
// Backpressure: none internally; push when full is accepted only together with a pop.
module fetch_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] head_dat,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_vld && (count != 2'd0);
  assign do_push = push_vld && ((count != 2'd2) || do_pop);

  // Flush only rewinds pointers; stale payload is masked by count.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch front end (PC, imem request channel, 2-entry instruction queue, decode slices).
// Latency: request t, response t+1, inst_valid t+2; redirect at t gives a request to the target at t+1.
// Backpressure: requests stall while in-flight + buffered reach 2; responses never stall. Option: FETCH_MISALIGN_CHECK_EN.
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            misalign_err,
`endif
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      fun3,
  output logic            fun7
);

  logic [XLEN-1:0] pc_q;
  logic [1:0]      discard_q;
  logic [1:0]      inflight;
  logic [1:0]      inst_cnt;
  logic [XLEN-1:0] req_pc_head;
  fetch_entry_t    rsp_entry;
  fetch_entry_t    inst_head;
  logic            fetch_halt;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_drop;
  logic            rsp_push;
  logic            inst_pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      misalign_err <= (redirect_pc[1:0] != 2'b00);
    end
  end

  assign fetch_halt    = misalign_err;
  assign imem_req_addr = pc_q;
`else
  assign fetch_halt    = 1'b0;
  assign imem_req_addr = {pc_q[XLEN-1:2], 2'b00};
`endif

  // Discarded responses still count against credit until they return.
  assign credit_ok      = ({1'b0, inflight} + {1'b0, inst_cnt}) < 3'd2;
  assign imem_req_valid = !rst && !redirect_valid && !fetch_halt && credit_ok;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop  = redirect_valid || (discard_q != 2'd0);
  assign rsp_push  = imem_rsp_valid && !rsp_drop;
  assign inst_pop  = inst_valid && inst_ready && !redirect_valid;
  assign rsp_entry = '{word: imem_rsp_data, pc: req_pc_head};

  // Its occupancy is the in-flight count; never flushed, since every request gets exactly one response.
  fetch_buf #(
    .W(XLEN)
  ) u_req_pc_q (
    .clk      (clk),
    .rst      (rst),
    .flush    (1'b0),
    .push_vld (req_fire),
    .push_dat (imem_req_addr),
    .pop_vld  (imem_rsp_valid),
    .head_dat (req_pc_head),
    .count    (inflight)
  );

  fetch_buf #(
    .W($bits(fetch_entry_t))
  ) u_inst_q (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push_vld (rsp_push),
    .push_dat (rsp_entry),
    .pop_vld  (inst_pop),
    .head_dat (inst_head),
    .count    (inst_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      discard_q <= 2'd0;
    end else if (redirect_valid) begin
      pc_q      <= redirect_pc;
      discard_q <= inflight - {1'b0, imem_rsp_valid};
    end else begin
      if (req_fire) begin
        pc_q <= pc_q + INSN_BYTES;
      end
      if (imem_rsp_valid && (discard_q != 2'd0)) begin
        discard_q <= discard_q - 2'd1;
      end
    end
  end

  assign inst_valid = (inst_cnt != 2'd0);
  assign inst       = inst_valid ? inst_head.word : '0;
  assign inst_pc    = inst_valid ? inst_head.pc : '0;
  assign opcode     = get_opcode(inst);
  assign fun3       = get_fun3(inst);
  assign fun7       = get_fun7(inst);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: fetch_unit against a transaction-level model (epoch-tagged requests, expected-word queue).
// Memory model answers in order after a programmable latency; optional FETCH_MISALIGN_CHECK_EN sequence.
module tb_fetch_unit;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  fun3;
  logic        fun7;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
    .misalign_err   (misalign_err),
`endif
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .opcode         (opcode),
    .fun3           (fun3),
    .fun7           (fun7)
  );

  typedef struct { logic [31:0] addr; int due; } mem_req_t;
  typedef struct { logic [31:0] addr; int epoch; } out_t;
  typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;
  typedef struct { logic [31:0] word; logic [6:0] op; logic [2:0] f3; logic f7; } dec_vec_t;

  mem_req_t    memq[$];
  out_t        outq[$];
  ent_t        expq[$];
  logic [31:0] mem_ovr [logic [31:0]];
  dec_vec_t    tbl [8];

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          lat = 1;
  int          delivered = 0;
  int          epoch = 0;
  logic [31:0] exp_pc;
  logic        halt = 1'b0;
  logic        fired = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    if (a == 32'h0) return 32'h0000_0013;
    return (a * 32'h9E37_79B9) + 32'h1;
  endfunction

  function automatic logic [31:0] fetch_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, then advance the model to the next posedge.
  task automatic step(input logic rrdy, input logic irdy, input logic redir, input logic [31:0] rpc);
    out_t o;
    ent_t e;
    logic exp_rv;
    @(negedge clk);
    cyc++;
    imem_req_ready = rrdy;
    inst_ready     = irdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    exp_rv = !redir && !halt && ((outq.size() + expq.size()) < 2);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, exp_pc);
    chk("inst_valid", 32'(inst_valid), 32'(expq.size() != 0));
    if (expq.size() != 0) begin
      chk("inst", inst, expq[0].word);
      chk("inst_pc", inst_pc, expq[0].pc);
      chk("opcode", 32'(opcode), 32'(expq[0].word[6:0]));
      chk("fun3", 32'(fun3), 32'(expq[0].word[14:12]));
      chk("fun7", 32'(fun7), 32'(expq[0].word[30]));
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("misalign_err", 32'(misalign_err), 32'(halt));
`endif
    fired = 1'b0;
    if (inst_valid && irdy && !redir && expq.size() != 0) begin
      void'(expq.pop_front());
      delivered++;
    end
    if (imem_rsp_valid && outq.size() != 0) begin
      o = outq.pop_front();
      if (!redir && o.epoch == epoch) begin
        e.pc   = o.addr;
        e.word = mem_word(o.addr);
        expq.push_back(e);
      end
    end
    if (imem_req_valid && rrdy) begin
      memq.push_back('{imem_req_addr, cyc + lat});
      o.addr  = exp_pc;
      o.epoch = epoch;
      outq.push_back(o);
      exp_pc = exp_pc + 32'd4;
      fired  = 1'b1;
    end
    if (redir) begin
      expq.delete();
      epoch++;
      exp_pc = fetch_target(rpc);
`ifdef FETCH_MISALIGN_CHECK_EN
      halt = (rpc[1:0] != 2'b00);
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_req_ready = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_slices", {21'h0, opcode, fun3, fun7}, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_misalign", 32'(misalign_err), 32'd0);
`endif
    memq.delete();
    outq.delete();
    expq.delete();
    exp_pc = 32'h0;
    epoch = 0;
    halt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
  endtask

  task automatic wait_inst(input string name, input int max_cyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      seen = inst_valid;
    end
    chk({name, "_timeout"}, 32'(seen), 32'd1);
  endtask

  initial begin
    logic        got;
    logic [31:0] r;
    logic [31:0] tgt;

    rst = 1'b1;
    imem_req_ready = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    exp_pc = 32'h0;

    tbl[0] = '{32'h4000_5033, 7'h33, 3'd5, 1'b1};
    tbl[1] = '{32'h0000_5033, 7'h33, 3'd5, 1'b0};
    tbl[2] = '{32'h0000_0013, 7'h13, 3'd0, 1'b0};
    tbl[3] = '{32'hFFF0_0093, 7'h13, 3'd0, 1'b1};
    tbl[4] = '{32'h0000_A503, 7'h03, 3'd2, 1'b0};
    tbl[5] = '{32'h0000_006F, 7'h6F, 3'd0, 1'b0};
    tbl[6] = '{32'h00B5_1463, 7'h63, 3'd1, 1'b0};
    tbl[7] = '{32'h4070_D713, 7'h13, 3'd5, 1'b1};
    for (int i = 0; i < 8; i++) mem_ovr[32'h3000 + 32'(4 * i)] = tbl[i].word;

    do_reset();

    // Startup: first word two cycles after the first request.
    lat = 1;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("start_inst_valid", 32'(inst_valid), 32'd1);
    chk("start_inst", inst, 32'h0000_0013);
    chk("start_inst_pc", inst_pc, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Decode stalled for 10 cycles: credit caps the front end at 2 words.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_inst_valid", 32'(inst_valid), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Latency 3 with two in flight, then redirect to 0x100.
    lat = 3;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      got = (outq.size() == 2);
    end
    chk("lat3_two_inflight_timeout", 32'(got), 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'h100);
    wait_inst("lat3_redirect", 20);
    chk("lat3_redirect_pc", inst_pc, 32'h100);

    // Redirect coinciding with a response and inst_ready.
    lat = 1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      got = fired;
    end
    chk("coincide_setup_timeout", 32'(got), 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h2000);
    chk("coincide_rsp_valid", 32'(imem_rsp_valid), 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("coincide_queue_empty", 32'(inst_valid), 32'd0);
    chk("coincide_req_valid", 32'(imem_req_valid), 32'd1);
    chk("coincide_req_addr", imem_req_addr, 32'h2000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Unaligned redirect target.
    step(1'b1, 1'b1, 1'b1, 32'h102);
    step(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("misalign_set", 32'(misalign_err), 32'd1);
    chk("misalign_no_req", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("misalign_still_idle", 32'(imem_req_valid), 32'd0);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("misalign_cleared", 32'(misalign_err), 32'd0);
    chk("misalign_resume_valid", 32'(imem_req_valid), 32'd1);
    chk("misalign_resume_addr", imem_req_addr, 32'h200);
    wait_inst("misalign_resume", 10);
    chk("misalign_resume_pc", inst_pc, 32'h200);
`else
    chk("unaligned_req_valid", 32'(imem_req_valid), 32'd1);
    chk("unaligned_req_addr", imem_req_addr, 32'h100);
`endif

    // Decode slice table.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 32'h3000 + 32'(4 * i));
      wait_inst("tbl", 10);
      chk("tbl_inst", inst, tbl[i].word);
      chk("tbl_opcode", 32'(opcode), 32'(tbl[i].op));
      chk("tbl_fun3", 32'(fun3), 32'(tbl[i].f3));
      chk("tbl_fun7", 32'(fun7), 32'(tbl[i].f7));
    end

    // Randomized traffic, with a reset in the middle.
    for (int ph = 0; ph < 6; ph++) begin
      if (ph == 3) do_reset();
      lat = $urandom_range(1, 3);
      for (int i = 0; i < 400; i++) begin
        r = $urandom;
        tgt = {16'h0, r[15:2], 2'b00};
        if (r[31:29] == 3'b000) tgt[1:0] = r[17:16];
        step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 30) == 0, tgt);
      end
    end

    // Drain with an aligned redirect so fetch is known to be running.
    lat = 1;
    step(1'b1, 1'b1, 1'b1, 32'h4000);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("delivered_min", 32'(delivered > 200), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
